multicycle_ctrl_v2: RTL and testbench

// Second-generation control FSM for the multicycle RV32I core. It decodes the full RV32I base
// set: ALU ops from funct3/funct7, all six branch conditions, JAL/JALR, LUI/AUIPC, plus

---
 rtl/multicycle_ctrl_v2.sv | 254 +++++++++++++++++++++++++
 tb/tb_multicycle_ctrl_v2.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_v2.sv
// Control FSM for the multicycle RV32I core: decodes the IR and sequences the shared datapath.
// Outputs are decoded combinationally from the state register (plus instr/zero/mem_ready).
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4 when memory is ready
// DECODE   | ALUOut <= oldPC + imm (branch/jump target), choose instruction class
// MEMADDR  | ALUOut <= rs1 + imm (load/store address)
// MEMREAD  | read data memory, wait for ready
// MEMWB    | rd <= MDR
// MEMWRITE | write data memory, wait for ready
// EXEC_R   | ALUOut <= rs1 op rs2
// EXEC_I   | ALUOut <= rs1 op imm
// ALUWB    | rd <= ALUOut
// BRANCH   | compare rs1/rs2, PC <= ALUOut when taken
// JAL      | PC <= ALUOut, ALUOut <= oldPC + 4
// JALR     | ALUOut <= rs1 + imm, then reuse JAL
// LUI      | ALUOut <= imm
// AUIPC    | ALUOut <= oldPC + imm
// TRAP     | illegal instruction, held until reset
module multicycle_ctrl_v2 #(
    parameter logic MEM_HANDSHAKE   = 1'b1,
    parameter logic TRAP_ON_ILLEGAL = 1'b1,
    parameter logic EN_UPPER        = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pcwrite,
    output logic        irwrite,
    output logic        adrsrc,
    output logic        memread,
    output logic        memwrite,
    output logic        regwrite,
    output logic        illegal,
    output logic [1:0]  resultsrc,
    output logic [1:0]  alusrca,
    output logic [1:0]  alusrcb,
    output logic [2:0]  immsrc,
    output logic [3:0]  aluctrl,
    output logic [3:0]  state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADDR  = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_AUIPC    = 4'd13,
        S_TRAP     = 4'd14,
        S_SPARE    = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_NULL   = 7'b0000000;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SLT  = 4'h5;
    localparam logic [3:0] ALU_SLTU = 4'h6;
    localparam logic [3:0] ALU_SLL  = 4'h7;
    localparam logic [3:0] ALU_SRL  = 4'h8;
    localparam logic [3:0] ALU_SRA  = 4'h9;
    localparam logic [3:0] ALU_PASSB = 4'hA;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    state_t state_q, state_d, illegal_next;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       rdy;
    logic       unused_instr_bits;

    assign opcode            = instr[6:0];
    assign funct3            = instr[14:12];
    assign funct7b5          = instr[30];
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};
    assign rdy               = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign illegal_next      = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
    assign state_o           = state_q;

    // funct7b5 selects sub only for register-register ops; shifts use it in both forms
    function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic b5, input logic is_r);
        case (f3)
            3'b000:  alu_dec = (is_r && b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_dec = ALU_SLL;
            3'b010:  alu_dec = ALU_SLT;
            3'b011:  alu_dec = ALU_SLTU;
            3'b100:  alu_dec = ALU_XOR;
            3'b101:  alu_dec = b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_dec = ALU_OR;
            default: alu_dec = ALU_AND;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!resetn) state_q <= S_FETCH;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = S_FETCH;
        pcwrite   = 1'b0;
        irwrite   = 1'b0;
        adrsrc    = 1'b0;
        memread   = 1'b0;
        memwrite  = 1'b0;
        regwrite  = 1'b0;
        illegal   = 1'b0;
        resultsrc = 2'b00;
        alusrca   = 2'b00;
        alusrcb   = 2'b00;
        immsrc    = IMM_I;
        aluctrl   = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                memread   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                irwrite   = rdy;
                pcwrite   = rdy;
                state_d   = rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                if (opcode == OP_BRANCH)   immsrc = IMM_B;
                else if (opcode == OP_JAL) immsrc = IMM_J;
                case (opcode)
                    OP_LOAD, OP_STORE:  state_d = S_MEMADDR;
                    OP_R:               state_d = S_EXEC_R;
                    OP_I:               state_d = S_EXEC_I;
                    OP_BRANCH:          state_d = S_BRANCH;
                    OP_JAL:             state_d = S_JAL;
                    OP_JALR:            state_d = EN_UPPER ? S_JALR  : illegal_next;
                    OP_LUI:             state_d = EN_UPPER ? S_LUI   : illegal_next;
                    OP_AUIPC:           state_d = EN_UPPER ? S_AUIPC : illegal_next;
                    OP_NULL, OP_FENCE:  state_d = S_FETCH;
                    default:            state_d = illegal_next;
                endcase
            end
            S_MEMADDR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                immsrc  = (opcode == OP_STORE) ? IMM_S : IMM_I;
                state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adrsrc  = 1'b1;
                memread = 1'b1;
                state_d = rdy ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                resultsrc = 2'b01;
                regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                adrsrc   = 1'b1;
                memwrite = 1'b1;
                state_d  = rdy ? S_FETCH : S_MEMWRITE;
            end
            S_EXEC_R: begin
                alusrca = 2'b10;
                aluctrl = alu_dec(funct3, funct7b5, 1'b1);
                state_d = S_ALUWB;
            end
            S_EXEC_I: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluctrl = alu_dec(funct3, funct7b5, 1'b0);
                state_d = S_ALUWB;
            end
            S_ALUWB: regwrite = 1'b1;
            S_BRANCH: begin
                alusrca = 2'b10;
                // slt/sltu yield 1 when "less than", so zero means the compare was false
                case (funct3)
                    3'b000: begin aluctrl = ALU_SUB;  pcwrite = zero;  end
                    3'b001: begin aluctrl = ALU_SUB;  pcwrite = !zero; end
                    3'b100: begin aluctrl = ALU_SLT;  pcwrite = !zero; end
                    3'b101: begin aluctrl = ALU_SLT;  pcwrite = zero;  end
                    3'b110: begin aluctrl = ALU_SLTU; pcwrite = !zero; end
                    3'b111: begin aluctrl = ALU_SLTU; pcwrite = zero;  end
                    default: state_d = illegal_next;
                endcase
            end
            S_JAL: begin
                alusrca = 2'b01;
                alusrcb = 2'b10;
                pcwrite = 1'b1;
                state_d = S_ALUWB;
            end
            S_JALR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                state_d = S_JAL;
            end
            S_LUI: begin
                alusrcb = 2'b01;
                immsrc  = IMM_U;
                aluctrl = ALU_PASSB;
                state_d = S_ALUWB;
            end
            S_AUIPC: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                immsrc  = IMM_U;
                state_d = S_ALUWB;
            end
            S_TRAP: begin
                illegal = 1'b1;
                state_d = S_TRAP;
            end
            default: state_d = S_FETCH;
        endcase
        // a reset during a memory wait must not leave a strobe or write enable asserted
        if (!resetn) begin
            pcwrite  = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            memread  = 1'b0;
            memwrite = 1'b0;
            illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_v2.sv
// Bench for multicycle_ctrl_v2: directed instruction scenarios followed by random instructions,
// each checked against an instruction-level state path and per-state control expectations.
`timescale 1ns/1ps
module tb_multicycle_ctrl_v2;

    typedef struct packed {
        logic       pcw, irw, adr, mr, mw, rw, ill;
        logic [1:0] res, a, b;
        logic [2:0] imm;
        logic [3:0] alu;
    } ctrl_t;

    localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, AND_ = 4'h2, OR_ = 4'h3, XOR_ = 4'h4,
                           SLT = 4'h5, SLTU = 4'h6, SLL = 4'h7, SRL = 4'h8, SRA = 4'h9, PASSB = 4'hA;

    logic        clk = 1'b0;
    logic        resetn, zero, mem_ready;
    logic [31:0] instr;
    logic        pcwrite, irwrite, adrsrc, memread, memwrite, regwrite, illegal;
    logic [1:0]  resultsrc, alusrca, alusrcb;
    logic [2:0]  immsrc;
    logic [3:0]  aluctrl, state_o;

    int n_assert = 0;
    int n_fail   = 0;

    multicycle_ctrl_v2 #(.MEM_HANDSHAKE(1'b1), .TRAP_ON_ILLEGAL(1'b1), .EN_UPPER(1'b1)) dut (
        .clk(clk), .resetn(resetn), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .irwrite(irwrite), .adrsrc(adrsrc), .memread(memread),
        .memwrite(memwrite), .regwrite(regwrite), .illegal(illegal), .resultsrc(resultsrc),
        .alusrca(alusrca), .alusrcb(alusrcb), .immsrc(immsrc), .aluctrl(aluctrl), .state_o(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // ALU operation an RV32I OP / OP-IMM instruction names
    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic b5, input bit is_r);
        logic [3:0] m [8];
        m = '{ADD, SLL, SLT, SLTU, XOR_, SRL, OR_, AND_};
        if (f3 == 3'd0 && is_r && b5) return SUB;
        if (f3 == 3'd5 && b5) return SRA;
        return m[f3];
    endfunction

    function automatic ctrl_t exp_ctrl(input int s, input logic [31:0] ins, input logic rdy,
                                       input logic taken, input logic rst_n);
        ctrl_t c;
        logic [6:0] op;
        logic [2:0] f3;
        op = ins[6:0];
        f3 = ins[14:12];
        c = '0;
        case (s)
            0:  begin c.mr = 1; c.b = 2; c.res = 2; c.irw = rdy; c.pcw = rdy; end
            1:  begin c.a = 1; c.b = 1; c.imm = (op == 7'h63) ? 3'd2 : (op == 7'h6F) ? 3'd3 : 3'd0; end
            2:  begin c.a = 2; c.b = 1; c.imm = (op == 7'h23) ? 3'd1 : 3'd0; end
            3:  begin c.adr = 1; c.mr = 1; end
            4:  begin c.res = 1; c.rw = 1; end
            5:  begin c.adr = 1; c.mw = 1; end
            6:  begin c.a = 2; c.alu = arith_op(f3, ins[30], 1'b1); end
            7:  begin c.a = 2; c.b = 1; c.alu = arith_op(f3, ins[30], 1'b0); end
            8:  c.rw = 1;
            9:  begin
                    c.a = 2;
                    c.pcw = taken;
                    if (f3 == 3'd0 || f3 == 3'd1)      c.alu = SUB;
                    else if (f3 == 3'd4 || f3 == 3'd5) c.alu = SLT;
                    else if (f3 == 3'd6 || f3 == 3'd7) c.alu = SLTU;
                end
            10: begin c.a = 1; c.b = 2; c.pcw = 1; end
            11: begin c.a = 2; c.b = 1; end
            12: begin c.b = 1; c.imm = 3'd4; c.alu = PASSB; end
            13: begin c.a = 1; c.b = 1; c.imm = 3'd4; end
            14: c.ill = 1;
            default: ;
        endcase
        if (!rst_n) begin
            c.pcw = 0; c.irw = 0; c.rw = 0; c.mr = 0; c.mw = 0; c.ill = 0;
        end
        return c;
    endfunction

    // sequence of states an instruction walks through (memory waits excluded)
    task automatic build_path(input logic [31:0] ins, output int path[$]);
        logic [2:0] f3;
        f3 = ins[14:12];
        case (ins[6:0])
            7'h03: path = '{0, 1, 2, 3, 4};
            7'h23: path = '{0, 1, 2, 5};
            7'h33: path = '{0, 1, 6, 8};
            7'h13: path = '{0, 1, 7, 8};
            7'h63: if (f3 == 3'd2 || f3 == 3'd3) path = '{0, 1, 9, 14}; else path = '{0, 1, 9};
            7'h6F: path = '{0, 1, 10, 8};
            7'h67: path = '{0, 1, 11, 10, 8};
            7'h37: path = '{0, 1, 12, 8};
            7'h17: path = '{0, 1, 13, 8};
            7'h00, 7'h0F: path = '{0, 1};
            default: path = '{0, 1, 14};
        endcase
    endtask

    function automatic ctrl_t observed();
        ctrl_t o;
        o = '{pcw: pcwrite, irw: irwrite, adr: adrsrc, mr: memread, mw: memwrite, rw: regwrite,
              ill: illegal, res: resultsrc, a: alusrca, b: alusrcb, imm: immsrc, alu: aluctrl};
        return o;
    endfunction

    task automatic trap_seq(input logic [31:0] ins);
        for (int k = 0; k < 20; k++) begin
            mem_ready = 1'($urandom_range(1));
            zero      = 1'($urandom_range(1));
            #4;
            chk("trap_state", 32'(state_o), 32'd14);
            chk("trap_ctrl", {12'b0, observed()}, {12'b0, exp_ctrl(14, ins, mem_ready, 1'b0, 1'b1)});
            @(posedge clk); #1;
        end
        resetn = 1'b0;
        #4;
        chk("trap_rst_ctrl", {12'b0, observed()}, {12'b0, exp_ctrl(14, ins, mem_ready, 1'b0, 1'b0)});
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    // opnd_mode: 0 random operands, 1 rs1==rs2, 2 rs1=1 rs2=2
    task automatic run_instr(input logic [31:0] ins, input int fixed_stall,
                             input int opnd_mode, input bit reset_in_wait);
        int path[$];
        int n3, nrw, exp_rw;
        logic [31:0] ra, rb;
        logic zb, taken;
        logic [2:0] f3;
        n3 = 0; nrw = 0; exp_rw = 0;
        f3 = ins[14:12];
        build_path(ins, path);
        instr = ins;
        ra = $urandom;
        rb = ($urandom_range(3) == 0) ? ra : $urandom;
        if (opnd_mode == 1) rb = ra;
        if (opnd_mode == 2) begin ra = 32'd1; rb = 32'd2; end
        // zero is what the datapath ALU would report; taken is the architectural branch outcome
        case (f3)
            3'd0:    begin zb = (ra == rb);                  taken = (ra == rb); end
            3'd1:    begin zb = (ra == rb);                  taken = (ra != rb); end
            3'd4:    begin zb = !($signed(ra) < $signed(rb)); taken = ($signed(ra) < $signed(rb)); end
            3'd5:    begin zb = !($signed(ra) < $signed(rb)); taken = ($signed(ra) >= $signed(rb)); end
            3'd6:    begin zb = !(ra < rb);                  taken = (ra < rb); end
            3'd7:    begin zb = !(ra < rb);                  taken = (ra >= rb); end
            default: begin zb = 1'($urandom_range(1));       taken = 1'b0; end
        endcase
        foreach (path[i]) begin
            int s;
            int waits;
            bit wait_st;
            logic rdy;
            s = path[i];
            waits = 0;
            wait_st = (s == 0 || s == 3 || s == 5);
            if (s == 4 || s == 8) exp_rw++;
            if (s == 14) begin
                trap_seq(ins);
                return;
            end
            do begin
                if (!wait_st)             rdy = 1'($urandom_range(1));
                else if (fixed_stall >= 0) rdy = (s == 0) ? 1'b1 : (waits >= fixed_stall);
                else                      rdy = (waits >= 6) || ($urandom_range(99) >= 30);
                if (reset_in_wait && s == 5 && waits == 1) begin
                    mem_ready = 1'b0;
                    resetn    = 1'b0;
                    #4;
                    chk("rstwait_state", 32'(state_o), 32'd5);
                    chk("rstwait_memwrite", 32'(memwrite), 32'd0);
                    chk("rstwait_ctrl", {12'b0, observed()}, {12'b0, exp_ctrl(5, ins, 1'b0, 1'b0, 1'b0)});
                    @(posedge clk); #1;
                    resetn = 1'b1;
                    return;
                end
                mem_ready = rdy;
                zero      = (s == 9) ? zb : 1'($urandom_range(1));
                #4;
                chk($sformatf("state@%0d", s), 32'(state_o), 32'(s));
                chk($sformatf("ctrl@s%0d_ins%h", s, ins), {12'b0, observed()},
                    {12'b0, exp_ctrl(s, ins, rdy, taken, 1'b1)});
                if (state_o == 4'd3) n3++;
                if (regwrite) nrw++;
                @(posedge clk); #1;
                waits++;
            end while (wait_st && !rdy);
        end
        chk("regwrite_count", 32'(nrw), 32'(exp_rw));
        if (fixed_stall >= 0 && ins[6:0] == 7'h03)
            chk("memread_hold", 32'(n3), 32'(fixed_stall + 1));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [12];
        logic [31:0] r;
        ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F, 7'h00, 7'h7F};
        r = $urandom;
        return {r[31:7], ops[$urandom_range(11)]};
    endfunction

    initial begin
        resetn = 1'b0; instr = 32'h0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b1;
        #3;
        chk("reset_state", 32'(state_o), 32'd0);
        chk("reset_ctrl", {12'b0, observed()}, {12'b0, exp_ctrl(0, 32'h0, 1'b1, 1'b0, 1'b0)});
        @(posedge clk); #1;
        resetn = 1'b1;

        run_instr(32'h002081B3, 0, 0, 1'b0);   // add x3,x1,x2
        run_instr(32'h00012083, 3, 0, 1'b0);   // lw x1,0(x2), 3 stall cycles
        run_instr(32'h00209463, 0, 2, 1'b0);   // bne, operands differ
        run_instr(32'h00209463, 0, 1, 1'b0);   // bne, operands equal
        run_instr(32'h0020D463, 0, 1, 1'b0);   // bge, operands equal
        run_instr(32'h000080E7, 0, 0, 1'b0);   // jalr x1,0(x1)
        run_instr(32'h0000007F, 0, 0, 1'b0);   // illegal opcode
        run_instr(32'h00112023, 10, 0, 1'b1);  // sw, reset while waiting
        run_instr(32'h000000B7, 0, 0, 1'b0);   // lui
        run_instr(32'h00000097, 0, 0, 1'b0);   // auipc

        for (int n = 0; n < 300; n++)
            run_instr(rand_instr(), -1, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
